// File: rtl/lsu_dbus.sv
// ============================================================================
// Module      : lsu_dbus
// Description : Single-outstanding load/store unit driving a byte-lane data
//               bus; optional alignment fault via LSU_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dbus #(
    parameter int XLEN = 64,
    parameter int AW   = 64,
    parameter int RDW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [RDW-1:0]    req_rd,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [AW-1:0]     dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [XLEN/8-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_data_ok,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              wb_valid,
    output logic [RDW-1:0]    wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              st_done,
    output logic              misalign
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_xfer;
    logic              w_misal;
    logic              w_accept;
    logic [1:0]        w_sz;
    logic [OFFW-1:0]   w_off;
    logic [NB-1:0]     w_strb_base;
    logic [NB-1:0]     w_strb;
    logic [XLEN-1:0]   w_wdata_sh;

    logic [OFFW-1:0]   r_off;
    logic [1:0]        r_sz;
    logic              r_uns;
    logic              r_store;
    logic [RDW-1:0]    r_rd;

    logic [XLEN-1:0]   w_rsh;
    logic [XLEN-1:0]   w_ldmask;
    logic              w_sign;
    logic [XLEN-1:0]   w_ld;

    assign w_xfer     = req_valid & req_ready;
    assign req_ready  = (r_state == ST_IDLE);
    assign dreq_valid = (r_state != ST_IDLE);
    assign w_off      = req_addr[OFFW-1:0];
    // A doubleword request on a 32-bit bus degrades to a word access.
    assign w_sz       = ((XLEN == 32) && (req_funct3[1:0] == 2'd3)) ? 2'd2 : req_funct3[1:0];

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_strb_base[i] = (i < (1 << w_sz));
        end
    end

    assign w_strb     = w_strb_base << w_off;
    assign w_wdata_sh = req_wdata << {w_off, 3'b000};

`ifdef LSU_MISALIGN_CHECK_EN
    logic [OFFW-1:0] w_lowmask;
    logic            r_misalign;

    always_comb begin
        for (int j = 0; j < OFFW; j++) begin
            w_lowmask[j] = (j < int'(w_sz));
        end
    end

    assign w_misal  = ((w_off & w_lowmask) != '0);
    assign misalign = r_misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_xfer & w_misal;
        end
    end
`else
    assign w_misal  = 1'b0;
    assign misalign = 1'b0;
`endif

    assign w_accept = w_xfer & ~w_misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (dresp_data_ok)  w_state_nxt = ST_IDLE;
                else if (flush)     w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (dresp_data_ok) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Load alignment: bring the addressed lane down to bit 0, then extend.
    assign w_rsh = dresp_data >> {r_off, 3'b000};

    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            w_ldmask[i] = (i < (8 << r_sz));
        end
        case (r_sz)
            2'd0:    w_sign = w_rsh[7];
            2'd1:    w_sign = w_rsh[15];
            2'd2:    w_sign = w_rsh[31];
            default: w_sign = w_rsh[XLEN-1];
        endcase
    end

    assign w_ld = (w_rsh & w_ldmask) | ({XLEN{w_sign & ~r_uns}} & ~w_ldmask);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dreq_addr   <= '0;
            dreq_size   <= '0;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            r_off       <= '0;
            r_sz        <= '0;
            r_uns       <= 1'b0;
            r_store     <= 1'b0;
            r_rd        <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            st_done     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            st_done  <= 1'b0;
            if ((r_state == ST_IDLE) && w_accept) begin
                dreq_addr   <= req_addr;
                dreq_size   <= {1'b0, w_sz};
                dreq_strobe <= req_store ? w_strb : '0;
                dreq_data   <= req_store ? w_wdata_sh : '0;
                r_off       <= w_off;
                r_sz        <= w_sz;
                r_uns       <= req_funct3[2] & ~req_store;
                r_store     <= req_store;
                r_rd        <= req_rd;
            end
            if ((r_state == ST_BUSY) && dresp_data_ok && !flush) begin
                if (r_store) begin
                    st_done <= 1'b1;
                end else begin
                    wb_valid <= 1'b1;
                    wb_rd    <= r_rd;
                    wb_data  <= w_ld;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_dbus.sv
// ============================================================================
// Module      : tb_lsu_dbus
// Description : Directed scoreboard bench for lsu_dbus (64-bit and 32-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_dbus;

    logic        clk;
    logic        rst;

    logic        req_valid, req_ready, req_store, flush;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        wb_valid, st_done, misalign;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    logic        s_req_valid, s_req_ready, s_req_store, s_flush;
    logic [2:0]  s_req_funct3;
    logic [31:0] s_req_addr, s_req_wdata;
    logic [4:0]  s_req_rd;
    logic        s_dreq_valid;
    logic [31:0] s_dreq_addr;
    logic [2:0]  s_dreq_size;
    logic [3:0]  s_dreq_strobe;
    logic [31:0] s_dreq_data;
    logic        s_dresp_data_ok;
    logic [31:0] s_dresp_data;
    logic        s_wb_valid, s_st_done, s_misalign;
    logic [4:0]  s_wb_rd;
    logic [31:0] s_wb_data;

    typedef struct {
        logic        is_store;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    lsu_dbus #(.XLEN(64), .AW(64), .RDW(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .misalign(misalign)
    );

    lsu_dbus #(.XLEN(32), .AW(32), .RDW(5)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_store(s_req_store),
        .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .req_rd(s_req_rd), .flush(s_flush),
        .dreq_valid(s_dreq_valid), .dreq_addr(s_dreq_addr), .dreq_size(s_dreq_size),
        .dreq_strobe(s_dreq_strobe), .dreq_data(s_dreq_data),
        .dresp_data_ok(s_dresp_data_ok), .dresp_data(s_dresp_data),
        .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
        .st_done(s_st_done), .misalign(s_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pulse(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        if (e.is_store) begin
            chk({tag, "_st_done"}, {63'd0, st_done}, 64'd1);
            chk({tag, "_no_wb"},   {63'd0, wb_valid}, 64'd0);
        end else begin
            chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
            chk({tag, "_wb_rd"},    {59'd0, wb_rd}, {59'd0, e.rd});
            chk({tag, "_wb_data"},  wb_data, e.data);
        end
    endtask

    // Issue one op on the 64-bit LSU; data_ok arrives after 'waits' extra busy cycles.
    task automatic op64(input string tag, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                        input logic [63:0] resp, input int waits, input logic [7:0] exp_strb,
                        input logic [63:0] exp_dd, input logic [63:0] exp_wb);
        exp_t e;
        chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        e.is_store = st; e.rd = rd; e.data = exp_wb;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        chk({tag, "_dvalid"}, {63'd0, dreq_valid}, 64'd1);
        chk({tag, "_daddr"},  dreq_addr, addr);
        chk({tag, "_strobe"}, {56'd0, dreq_strobe}, {56'd0, exp_strb});
        chk({tag, "_ddata"},  dreq_data, exp_dd);
        for (int k = 0; k < waits; k++) begin
            tick();
            chk({tag, "_dvalid_hold"}, {63'd0, dreq_valid}, 64'd1);
        end
        dresp_data_ok = 1'b1; dresp_data = resp;
        tick();
        dresp_data_ok = 1'b0;
        check_pulse(tag);
        chk({tag, "_dvalid_drop"}, {63'd0, dreq_valid}, 64'd0);
        chk({tag, "_ready_back"},  {63'd0, req_ready}, 64'd1);
        tick();
        chk({tag, "_pulse_end"}, {62'd0, wb_valid, st_done}, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
        flush = 0; dresp_data_ok = 0; dresp_data = 0;
        s_req_valid = 0; s_req_store = 0; s_req_funct3 = 0; s_req_addr = 0; s_req_wdata = 0;
        s_req_rd = 0; s_flush = 0; s_dresp_data_ok = 0; s_dresp_data = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  {63'd0, req_ready}, 64'd1);
        chk("rst_outs",   {59'd0, dreq_valid, wb_valid, st_done, misalign, |dreq_strobe}, 64'd0);
        chk("rst_data",   dreq_addr | dreq_data | wb_data, 64'd0);
        rst = 1'b1;
        tick();

        op64("sd", 1'b1, 3'b011, 64'h1000, 64'h1122334455667788, 5'd0, 64'd0, 1,
             8'hFF, 64'h1122334455667788, 64'd0);
        chk("sd_size", {61'd0, dreq_size}, 64'd3);
        op64("lb", 1'b0, 3'b000, 64'h2003, 64'd0, 5'd7, 64'h0000000080000000, 0,
             8'h00, 64'd0, 64'hFFFFFFFFFFFFFF80);
        op64("lbu", 1'b0, 3'b100, 64'h2003, 64'd0, 5'd8, 64'h0000000080000000, 0,
             8'h00, 64'd0, 64'h0000000000000080);
        op64("sh", 1'b1, 3'b001, 64'h3006, 64'hABCD, 5'd0, 64'd0, 2,
             8'hC0, 64'hABCD000000000000, 64'd0);
        op64("lw", 1'b0, 3'b010, 64'h2004, 64'd0, 5'd9, 64'h8765432100000000, 1,
             8'h00, 64'd0, 64'hFFFFFFFF87654321);
        op64("lwu", 1'b0, 3'b110, 64'h2004, 64'd0, 5'd10, 64'h8765432100000000, 0,
             8'h00, 64'd0, 64'h0000000087654321);
        op64("lhu", 1'b0, 3'b101, 64'h2002, 64'd0, 5'd11, 64'h00000000F00D0000, 0,
             8'h00, 64'd0, 64'h000000000000F00D);

        // Flush while busy: the bus is still owed its response, but no writeback.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8; req_rd = 5'd3;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_drain_valid", {63'd0, dreq_valid}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("fl_hold", {63'd0, dreq_valid}, 64'd1);
        end
        dresp_data_ok = 1'b1; dresp_data = 64'h5555;
        tick();
        dresp_data_ok = 1'b0;
        chk("fl_no_pulse", {62'd0, wb_valid, st_done}, 64'd0);
        chk("fl_ready",    {63'd0, req_ready}, 64'd1);
        chk("fl_dvalid",   {63'd0, dreq_valid}, 64'd0);

        // Back-to-back: next op accepted in the writeback cycle.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b001; req_addr = 64'h2002; req_rd = 5'd12;
        sb.push_back('{is_store: 1'b0, rd: 5'd12, data: 64'hFFFFFFFFFFFF8001});
        tick();
        req_valid = 1'b0;
        dresp_data_ok = 1'b1; dresp_data = 64'h0000000080010000;
        tick();
        dresp_data_ok = 1'b0;
        check_pulse("b2b");
        chk("b2b_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 64'h5; req_wdata = 64'h7F;
        tick();
        req_valid = 1'b0;
        chk("b2b_dvalid", {63'd0, dreq_valid}, 64'd1);
        chk("sb_strobe",  {56'd0, dreq_strobe}, 64'h20);
        chk("sb_ddata",   dreq_data, 64'h00007F0000000000);
        rst = 1'b0;
        #1;
        chk("rst_mid_dvalid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_mid_ready",  {63'd0, req_ready}, 64'd1);
        tick();
        rst = 1'b1;
        chk("rst_mid_pulse", {62'd0, wb_valid, st_done}, 64'd0);
        tick();
        chk("rst_mid_pulse2", {62'd0, wb_valid, st_done}, 64'd0);

`ifdef LSU_MISALIGN_CHECK_EN
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'h4002; req_rd = 5'd4;
        tick();
        req_valid = 1'b0;
        chk("mis_pulse",  {63'd0, misalign}, 64'd1);
        chk("mis_dvalid", {63'd0, dreq_valid}, 64'd0);
        chk("mis_ready",  {63'd0, req_ready}, 64'd1);
        tick();
        chk("mis_end",    {63'd0, misalign}, 64'd0);
        chk("mis_dvalid2", {63'd0, dreq_valid}, 64'd0);
`else
        s_req_valid = 1'b1; s_req_store = 1'b1; s_req_funct3 = 3'b010;
        s_req_addr = 32'h4002; s_req_wdata = 32'h12345678;
        tick();
        s_req_valid = 1'b0;
        chk("s32_dvalid", {63'd0, s_dreq_valid}, 64'd1);
        chk("s32_strobe", {60'd0, s_dreq_strobe}, 64'hC);
        chk("s32_ddata",  {32'd0, s_dreq_data}, 64'h56780000);
        chk("s32_mis",    {63'd0, s_misalign}, 64'd0);
        s_dresp_data_ok = 1'b1;
        tick();
        s_dresp_data_ok = 1'b0;
        chk("s32_st_done", {63'd0, s_st_done}, 64'd1);
        tick();
        s_req_valid = 1'b1; s_req_store = 1'b0; s_req_funct3 = 3'b011;
        s_req_addr = 32'h8; s_req_rd = 5'd6;
        tick();
        s_req_valid = 1'b0;
        chk("s32_ld_size", {61'd0, s_dreq_size}, 64'd2);
        s_dresp_data_ok = 1'b1; s_dresp_data = 32'h80000000;
        tick();
        s_dresp_data_ok = 1'b0;
        chk("s32_ld_wb",   {63'd0, s_wb_valid}, 64'd1);
        chk("s32_ld_data", {32'd0, s_wb_data}, 64'h80000000);
        tick();
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
